// File: rtl/global_ldst_merge_pkg.sv
// Shared constants and AXI channel types for global_ldst_merge.
// Cluster ports carry ClusterAxiDataWidth-bit data. The wide port carries
// NrClusters x ClusterAxiDataWidth bits, with cluster 0 in the LSBs.
package global_ldst_merge_pkg;

  localparam int unsigned NrClusters          = 4;
  localparam int unsigned ClusterAxiDataWidth = 8;
  localparam int unsigned AxiAddrWidth        = 32;
  localparam int unsigned AxiIdWidth          = 4;
  localparam int unsigned WideDataWidth       = NrClusters * ClusterAxiDataWidth;
  localparam int unsigned ClusterStrbWidth    = ClusterAxiDataWidth / 8;
  localparam int unsigned WideStrbWidth       = WideDataWidth / 8;
  // AXI size code of one full wide beat.
  localparam logic [2:0]  WideAxiSize         = 3'($clog2(WideStrbWidth));

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [3:0]              cache;
  } ax_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } b_chan_t;

  typedef struct packed {
    logic [ClusterAxiDataWidth-1:0] data;
    logic [ClusterStrbWidth-1:0]    strb;
    logic                           last;
  } cl_w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]          id;
    logic [ClusterAxiDataWidth-1:0] data;
    logic [1:0]                     resp;
    logic                           last;
  } cl_r_chan_t;

  typedef struct packed {
    logic [WideDataWidth-1:0] data;
    logic [WideStrbWidth-1:0] strb;
    logic                     last;
  } wide_w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]    id;
    logic [WideDataWidth-1:0] data;
    logic [1:0]               resp;
    logic                     last;
  } wide_r_chan_t;

  typedef struct packed {
    ax_chan_t   aw;
    logic       aw_valid;
    cl_w_chan_t w;
    logic       w_valid;
    logic       b_ready;
    ax_chan_t   ar;
    logic       ar_valid;
    logic       r_ready;
  } cl_req_t;

  typedef struct packed {
    logic       aw_ready;
    logic       ar_ready;
    logic       w_ready;
    logic       b_valid;
    b_chan_t    b;
    logic       r_valid;
    cl_r_chan_t r;
  } cl_resp_t;

  typedef struct packed {
    ax_chan_t     aw;
    logic         aw_valid;
    wide_w_chan_t w;
    logic         w_valid;
    logic         b_ready;
    ax_chan_t     ar;
    logic         ar_valid;
    logic         r_ready;
  } wide_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    b_chan_t      b;
    logic         r_valid;
    wide_r_chan_t r;
  } wide_resp_t;

endpackage

// File: rtl/ldst_addr_join.sv
// Joins one address channel (AR or AW) from NrClusters clusters into one request.
// Each cluster's request is captured into a held flag. Cluster 0's payload is the
// only one forwarded, so it is the only payload stored. The joined request goes
// valid one cycle after the last capture and is fed straight from registers.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   full_i         outstanding-burst counter is saturated; block new captures
//   valid_i        per-cluster request valid
//   chan0_i        cluster 0 payload
//   ready_o        per-cluster ready
//   valid_o        joined request valid
//   chan_o         joined payload (cluster 0)
//   ready_i        downstream ready
//   held_o         per-cluster held flags
module ldst_addr_join #(
  parameter type         chan_t     = logic,
  parameter int unsigned NrClusters = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  full_i,
  input  logic [NrClusters-1:0] valid_i,
  input  chan_t                 chan0_i,
  output logic [NrClusters-1:0] ready_o,
  output logic                  valid_o,
  output chan_t                 chan_o,
  input  logic                  ready_i,
  output logic [NrClusters-1:0] held_o
);

  logic [NrClusters-1:0] held_q, held_d;
  chan_t                 chan_q, chan_d;
  logic                  issue;

  assign ready_o = ~held_q & {NrClusters{~full_i}};
  assign valid_o = &held_q;
  assign chan_o  = chan_q;
  assign held_o  = held_q;
  assign issue   = valid_o & ready_i;

  // Issue needs every flag set, which forces every ready low,
  // so an issue and a capture never happen in the same cycle.
  always_comb begin
    held_d = held_q;
    chan_d = chan_q;
    if (issue) begin
      held_d = '0;
    end
    for (int unsigned c = 0; c < NrClusters; c++) begin
      if (valid_i[c] && ready_o[c]) begin
        held_d[c] = 1'b1;
      end
    end
    if (valid_i[0] && ready_o[0]) begin
      chan_d = chan0_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_q <= '0;
      chan_q <= '0;
    end else begin
      held_q <= held_d;
      chan_q <= chan_d;
    end
  end

endmodule

// File: rtl/global_ldst_merge.sv
// Merges NrClusters per-cluster AXI ports into one wide AXI master port.
// AR/AW are joined through held registers. R is split into per-cluster slices.
// W beats are concatenated. B is forked to every cluster. Separate read and
// write counters cap in-flight bursts at MaxOutstanding.
// Optional macro GLOBAL_LDST_R_SPILL_EN adds a spill register on the wide R
// channel, which gives 1-cycle R latency at full throughput.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   axi_req_i      per-cluster requests     axi_resp_o  per-cluster responses
//   axi_req_o      wide request to memory   axi_resp_i  wide response from memory
module global_ldst_merge
  import global_ldst_merge_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  cl_req_t  [NrClusters-1:0]   axi_req_i,
  output cl_resp_t [NrClusters-1:0]   axi_resp_o,
  output wide_req_t                   axi_req_o,
  input  wide_resp_t                  axi_resp_i
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding) + 1;
  localparam int unsigned Cw       = ClusterAxiDataWidth;
  typedef logic [CntWidth-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(MaxOutstanding);

  cnt_t                  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic                  rd_full, wr_full, rd_dec, wr_dec;
  logic [NrClusters-1:0] ar_valid, ar_ready, aw_valid, aw_ready, ar_held, aw_held;
  logic [NrClusters-1:0] w_valid, r_ready_vec, b_ready_vec, b_accept;
  logic [NrClusters-1:0] b_done_q, b_done_d;
  ax_chan_t              ar_wide, aw_wide;
  logic                  ar_wide_valid, aw_wide_valid, ar_issue, aw_issue;
  logic                  w_all_valid, b_all;
  wide_r_chan_t          r_chan;
  logic                  r_valid, r_ready, wide_r_ready;
  logic                  unused_req;

  // Payloads of clusters other than 0 (and the cluster size fields) are not forwarded.
  assign unused_req = ^axi_req_i;

  always_comb begin
    ar_valid    = '0;
    aw_valid    = '0;
    w_valid     = '0;
    r_ready_vec = '0;
    b_ready_vec = '0;
    for (int unsigned c = 0; c < NrClusters; c++) begin
      ar_valid[c]    = axi_req_i[c].ar_valid;
      aw_valid[c]    = axi_req_i[c].aw_valid;
      w_valid[c]     = axi_req_i[c].w_valid;
      r_ready_vec[c] = axi_req_i[c].r_ready;
      b_ready_vec[c] = axi_req_i[c].b_ready;
    end
  end

  assign rd_full = (rd_cnt_q == CntMax);
  assign wr_full = (wr_cnt_q == CntMax);

  ldst_addr_join #(
    .chan_t     (ax_chan_t),
    .NrClusters (NrClusters)
  ) u_ar_join (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .full_i  (rd_full),
    .valid_i (ar_valid),
    .chan0_i (axi_req_i[0].ar),
    .ready_o (ar_ready),
    .valid_o (ar_wide_valid),
    .chan_o  (ar_wide),
    .ready_i (axi_resp_i.ar_ready),
    .held_o  (ar_held)
  );

  ldst_addr_join #(
    .chan_t     (ax_chan_t),
    .NrClusters (NrClusters)
  ) u_aw_join (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .full_i  (wr_full),
    .valid_i (aw_valid),
    .chan0_i (axi_req_i[0].aw),
    .ready_o (aw_ready),
    .valid_o (aw_wide_valid),
    .chan_o  (aw_wide),
    .ready_i (axi_resp_i.aw_ready),
    .held_o  (aw_held)
  );

  assign ar_issue = ar_wide_valid & axi_resp_i.ar_ready;
  assign aw_issue = aw_wide_valid & axi_resp_i.aw_ready;

  // R channel source: the raw wide R, or a two-slot spill buffer.
  assign r_ready = &r_ready_vec;
`ifdef GLOBAL_LDST_R_SPILL_EN
  logic         spill_a_full_q, spill_b_full_q;
  wide_r_chan_t spill_a_q, spill_b_q;
  logic         spill_a_fill, spill_a_drain, spill_b_fill, spill_b_drain;

  assign wide_r_ready  = ~spill_a_full_q | ~spill_b_full_q;
  assign spill_a_fill  = axi_resp_i.r_valid & wide_r_ready;
  assign spill_a_drain = spill_a_full_q & ~spill_b_full_q;
  // Slot B only fills when A must drain but the clusters are stalled.
  assign spill_b_fill  = spill_a_drain & ~r_ready;
  assign spill_b_drain = spill_b_full_q & r_ready;
  assign r_valid       = spill_a_full_q | spill_b_full_q;
  assign r_chan        = spill_b_full_q ? spill_b_q : spill_a_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spill_a_full_q <= 1'b0;
      spill_b_full_q <= 1'b0;
      spill_a_q      <= '0;
      spill_b_q      <= '0;
    end else begin
      if (spill_a_fill) spill_a_q <= axi_resp_i.r;
      if (spill_a_fill || spill_a_drain) spill_a_full_q <= spill_a_fill;
      if (spill_b_fill) spill_b_q <= spill_a_q;
      if (spill_b_fill || spill_b_drain) spill_b_full_q <= spill_b_fill;
    end
  end
`else
  assign wide_r_ready = r_ready;
  assign r_valid      = axi_resp_i.r_valid;
  assign r_chan       = axi_resp_i.r;
`endif

  assign rd_dec = r_valid & r_ready & r_chan.last;

  assign w_all_valid = &w_valid;

  // B fork: the wide B is consumed once every cluster has taken it, now or earlier.
  assign b_accept = {NrClusters{axi_resp_i.b_valid}} & ~b_done_q & b_ready_vec;
  assign b_all    = axi_resp_i.b_valid & (&(b_done_q | b_accept));
  assign b_done_d = b_all ? '0 : (b_done_q | b_accept);
  assign wr_dec   = b_all;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (ar_issue && !rd_dec) rd_cnt_d = rd_cnt_q + cnt_t'(1);
    else if (!ar_issue && rd_dec) rd_cnt_d = rd_cnt_q - cnt_t'(1);
    wr_cnt_d = wr_cnt_q;
    if (aw_issue && !wr_dec) wr_cnt_d = wr_cnt_q + cnt_t'(1);
    else if (!aw_issue && wr_dec) wr_cnt_d = wr_cnt_q - cnt_t'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      b_done_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      b_done_q <= b_done_d;
    end
  end

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.ar       = ar_wide;
    axi_req_o.ar.size  = WideAxiSize;
    axi_req_o.ar_valid = ar_wide_valid;
    axi_req_o.aw       = aw_wide;
    axi_req_o.aw.size  = WideAxiSize;
    axi_req_o.aw_valid = aw_wide_valid;
    axi_req_o.w_valid  = w_all_valid;
    axi_req_o.w.last   = axi_req_i[0].w.last;
    axi_req_o.b_ready  = b_all;
    axi_req_o.r_ready  = wide_r_ready;
    for (int unsigned c = 0; c < NrClusters; c++) begin
      axi_req_o.w.data[c*Cw +: Cw] = axi_req_i[c].w.data;
      axi_req_o.w.strb[c*ClusterStrbWidth +: ClusterStrbWidth] = axi_req_i[c].w.strb;
    end
  end

  always_comb begin
    axi_resp_o = '0;
    for (int unsigned c = 0; c < NrClusters; c++) begin
      axi_resp_o[c].ar_ready = ar_ready[c];
      axi_resp_o[c].aw_ready = aw_ready[c];
      axi_resp_o[c].w_ready  = axi_resp_i.w_ready & w_all_valid;
      axi_resp_o[c].b_valid  = axi_resp_i.b_valid & ~b_done_q[c];
      axi_resp_o[c].b        = axi_resp_i.b;
      axi_resp_o[c].r_valid  = r_valid;
      axi_resp_o[c].r.id     = r_chan.id;
      axi_resp_o[c].r.resp   = r_chan.resp;
      axi_resp_o[c].r.last   = r_chan.last;
      axi_resp_o[c].r.data   = r_chan.data[c*Cw +: Cw];
    end
  end

endmodule
